// File: rtl/imem_fetch_unit.sv
// Instruction store plus program-counter sequencer: load the program, run it from PC 0,
// and stop on a halt word, an out-of-range PC or the cycle budget.  Optional macro IMEM_WRAP_EN.
module imem_fetch_unit #(
    parameter int              IW         = 16,
    parameter int              AW         = 5,
    parameter int              PCW        = 32,
    parameter int              MAX_CYCLES = 125,
    parameter logic [IW-1:0]   HALT_WORD  = 16'hFFFF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load_we,
    input  logic [AW-1:0]  load_addr,
    input  logic [IW-1:0]  load_data,
    input  logic           start,
    input  logic           stall,
    input  logic           pc_sel,
    input  logic [PCW-1:0] pc_target,
    output logic [IW-1:0]  instr,
    output logic [PCW-1:0] pc,
    output logic           instr_valid,
    output logic           running,
    output logic           done,
    output logic [1:0]     done_cause,
    output logic [PCW-1:0] cycle_count
);

    localparam int             DEPTH      = 1 << AW;
    localparam logic [PCW-1:0] LAST_CYCLE = PCW'(MAX_CYCLES - 1);

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_HALT    = 2'b01;
    localparam logic [1:0] CAUSE_RANGE   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] mem [DEPTH];
    logic          in_range;
    logic [1:0]    stop_cause;
    logic          stop;
    logic          launch;

    // Branch/stall selection; with wrapping enabled the result is folded into the memory range.
    function automatic logic [PCW-1:0] next_pc(
        input logic [PCW-1:0] cur,
        input logic           hold,
        input logic           take,
        input logic [PCW-1:0] target
    );
        logic [PCW-1:0] nxt;
        if (hold)
            nxt = cur;
        else if (take)
            nxt = target;
        else
            nxt = cur + PCW'(1);
`ifdef IMEM_WRAP_EN
        nxt = {{(PCW-AW){1'b0}}, nxt[AW-1:0]};
`endif
        return nxt;
    endfunction

    // Halt outranks range, which outranks the budget.
    function automatic logic [1:0] stop_reason(
        input logic           vld,
        input logic [IW-1:0]  word,
        input logic           inr,
        input logic [PCW-1:0] cnt
    );
        logic [1:0] cause;
        if (vld && (word == HALT_WORD))
            cause = CAUSE_HALT;
        else if (!inr)
            cause = CAUSE_RANGE;
        else if (cnt == LAST_CYCLE)
            cause = CAUSE_TIMEOUT;
        else
            cause = CAUSE_NONE;
        return cause;
    endfunction

`ifdef IMEM_WRAP_EN
    assign in_range = 1'b1;
`else
    localparam logic [PCW-1:0] DEPTH_PC = PCW'(DEPTH);
    assign in_range = (pc < DEPTH_PC);
`endif

    assign instr      = mem[pc[AW-1:0]];
    assign stop_cause = stop_reason(instr_valid, instr, in_range, cycle_count);
    assign stop       = (state == RUN) && (stop_cause != CAUSE_NONE);
    assign launch     = (state != RUN) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (stop)  state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running     = (state == RUN);
        done        = (state == DONE);
        instr_valid = (state == RUN) && in_range;
    end

    // On the stopping cycle the PC freezes but that cycle is still counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            cycle_count <= '0;
            done_cause  <= CAUSE_NONE;
        end else if (launch) begin
            pc          <= '0;
            cycle_count <= '0;
            done_cause  <= CAUSE_NONE;
        end else if (state == RUN) begin
            cycle_count <= cycle_count + PCW'(1);
            if (stop)
                done_cause <= stop_cause;
            else
                pc <= next_pc(pc, stall, pc_sel, pc_target);
        end
    end

    // Program memory keeps its contents across reset; writes are locked out while running.
    always_ff @(posedge clk) begin
        if (load_we && (state != RUN))
            mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomised bench for imem_fetch_unit against a cycle-level program-execution model.
module tb_imem_fetch_unit;
    localparam int          IW    = 16;
    localparam int          AW    = 5;
    localparam int          PCW   = 32;
    localparam int          MAXC  = 125;
    localparam int          DEPTH = 32;
    localparam logic [15:0] HALT  = 16'hFFFF;
`ifdef IMEM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          start;
    logic          stall;
    logic          pc_sel;
    logic [31:0]   pc_target;
    logic [IW-1:0] instr;
    logic [31:0]   pc;
    logic          instr_valid;
    logic          running;
    logic          done;
    logic [1:0]    done_cause;
    logic [31:0]   cycle_count;

    imem_fetch_unit #(
        .IW(IW), .AW(AW), .PCW(PCW), .MAX_CYCLES(MAXC), .HALT_WORD(HALT)
    ) dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .start(start), .stall(stall), .pc_sel(pc_sel),
        .pc_target(pc_target), .instr(instr), .pc(pc), .instr_valid(instr_valid),
        .running(running), .done(done), .done_cause(done_cause), .cycle_count(cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what the program should look like, step by step.
    logic [15:0] mem_model [DEPTH];
    logic [31:0] exp_pc;
    logic [31:0] exp_cc;
    logic [1:0]  exp_cause;
    bit          m_running;
    bit          m_done;

    logic [68:0] dut_status;
    assign dut_status = {running, done, instr_valid, done_cause, pc, cycle_count};

    function automatic bit exp_valid();
        return m_running && (WRAP || (exp_pc < DEPTH));
    endfunction

    function automatic logic [68:0] exp_status();
        return {m_running, m_done, exp_valid(), exp_cause, exp_pc, exp_cc};
    endfunction

    task automatic model_reset();
        m_running = 0; m_done = 0; exp_pc = 0; exp_cc = 0; exp_cause = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cycle(input bit st, input bit we, input logic [4:0] a, input logic [15:0] d,
                               input bit sl, input bit ps, input logic [31:0] tg);
        logic [1:0] c;
        start = st; load_we = we; load_addr = a; load_data = d;
        stall = sl; pc_sel = ps; pc_target = tg;
        if (m_running) begin
            c = 2'b00;
            if (exp_valid() && mem_model[exp_pc[4:0]] == HALT) c = 2'b01;
            else if (!WRAP && exp_pc >= DEPTH)                c = 2'b10;
            else if (exp_cc == MAXC - 1)                       c = 2'b11;
            exp_cc = exp_cc + 1;
            if (c != 2'b00) begin
                m_running = 0; m_done = 1; exp_cause = c;
            end else if (!sl) begin
                exp_pc = ps ? tg : exp_pc + 1;
                if (WRAP) exp_pc = exp_pc % DEPTH;
            end
        end else begin
            if (we) mem_model[a] = d;
            if (st) begin
                m_running = 1; m_done = 0; exp_pc = 0; exp_cc = 0; exp_cause = 0;
            end
        end
        tick();
        start = 0; load_we = 0; stall = 0; pc_sel = 0;
    endtask

    task automatic test_reset();
        reset = 1; start = 0; load_we = 0; load_addr = 0; load_data = 0;
        stall = 0; pc_sel = 0; pc_target = 0;
        model_reset();
        repeat (2) tick();
        reset = 0;
        tick();
        checks++; if (running !== 1'b0)     begin errors++; $display("FAIL reset_running got %b want 0", running); end
        checks++; if (done !== 1'b0)        begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (done_cause !== 2'b00) begin errors++; $display("FAIL reset_cause got %b want 00", done_cause); end
        checks++; if (pc !== 32'd0)         begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cycle_count); end
    endtask

    task automatic test_load();
        for (int a = 0; a < DEPTH; a++)
            drive_cycle(0, 1, 5'(a), 16'($urandom_range(0, 16'hFFFE)), 0, 0, 0);
        checks++;
        if (instr !== mem_model[0]) begin errors++; $display("FAIL load_readback got %h want %h", instr, mem_model[0]); end
        checks++;
        if (dut_status !== exp_status()) begin errors++; $display("FAIL load_idle got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_halt();
        int n;
        drive_cycle(0, 1, 5'd0, 16'd1, 0, 0, 0);
        drive_cycle(0, 1, 5'd1, 16'd2, 0, 0, 0);
        drive_cycle(0, 1, 5'd2, 16'd3, 0, 0, 0);
        drive_cycle(0, 1, 5'd3, HALT, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (m_running && n < 40) begin
            checks++;
            if (dut_status !== exp_status()) begin errors++; $display("FAIL halt_step%0d got %h want %h", n, dut_status, exp_status()); end
            checks++;
            if (instr !== mem_model[exp_pc[4:0]]) begin errors++; $display("FAIL halt_instr%0d got %h want %h", n, instr, mem_model[exp_pc[4:0]]); end
            drive_cycle(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++; if (done !== 1'b1)          begin errors++; $display("FAIL halt_done got %b want 1", done); end
        checks++; if (done_cause !== 2'b01)   begin errors++; $display("FAIL halt_cause got %b want 01", done_cause); end
        checks++; if (pc !== 32'd3)           begin errors++; $display("FAIL halt_pc got %0d want 3", pc); end
        checks++; if (cycle_count !== 32'd4)  begin errors++; $display("FAIL halt_count got %0d want 4", cycle_count); end
    endtask

    task automatic test_out_of_range();
        int n;
        logic [1:0]  want_cause;
        logic [31:0] want_pc;
        logic [31:0] want_cc;
        bit          saw_wrap;
        for (int a = 0; a < 4; a++)
            drive_cycle(0, 1, 5'(a), 16'($urandom_range(0, 16'hFFFE)), 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        n = 0;
        saw_wrap = 0;
        while (m_running && n < 200) begin
            checks++;
            if (dut_status !== exp_status()) begin errors++; $display("FAIL range_step%0d got %h want %h", n, dut_status, exp_status()); end
            if (pc == 32'd31) saw_wrap = 1;
            drive_cycle(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        if (WRAP) begin
            want_cause = 2'b11; want_pc = (MAXC - 1) % DEPTH; want_cc = MAXC;
        end else begin
            want_cause = 2'b10; want_pc = 32'd32; want_cc = 32'd33;
        end
        checks++; if (done_cause !== want_cause) begin errors++; $display("FAIL range_cause got %b want %b", done_cause, want_cause); end
        checks++; if (pc !== want_pc)            begin errors++; $display("FAIL range_pc got %0d want %0d", pc, want_pc); end
        checks++; if (cycle_count !== want_cc)   begin errors++; $display("FAIL range_count got %0d want %0d", cycle_count, want_cc); end
        checks++; if (saw_wrap !== 1'b1)         begin errors++; $display("FAIL range_reach31 got %b want 1", saw_wrap); end
    endtask

    task automatic test_timeout();
        int n;
        drive_cycle(0, 1, 5'd0, 16'd1, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (m_running && n < 200) begin
            checks++;
            if (dut_status !== exp_status()) begin errors++; $display("FAIL timeout_step%0d got %h want %h", n, dut_status, exp_status()); end
            drive_cycle(0, 0, 0, 0, 0, 1, 32'd0);
            n++;
        end
        checks++; if (done_cause !== 2'b11)          begin errors++; $display("FAIL timeout_cause got %b want 11", done_cause); end
        checks++; if (cycle_count !== 32'(MAXC))     begin errors++; $display("FAIL timeout_count got %0d want %0d", cycle_count, MAXC); end
        checks++; if (pc !== 32'd0)                  begin errors++; $display("FAIL timeout_pc got %0d want 0", pc); end
    endtask

    // Leaves the run active for the mid-run reset scenario.
    task automatic test_stall();
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (pc !== 32'd2)               begin errors++; $display("FAIL stall_pc%0d got %0d want 2", i, pc); end
            checks++; if (cycle_count !== 32'(2 + i)) begin errors++; $display("FAIL stall_count%0d got %0d want %0d", i, cycle_count, 2 + i); end
            drive_cycle(0, 0, 0, 0, 1, 1, 32'd17);
        end
        checks++; if (pc !== 32'd2)          begin errors++; $display("FAIL stall_release_pc got %0d want 2", pc); end
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("FAIL stall_release_count got %0d want 5", cycle_count); end
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dut_status !== exp_status()) begin errors++; $display("FAIL stall_resume got %h want %h", dut_status, exp_status()); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        n = 0;
        while (exp_pc != 32'd5 && n < 10) begin
            drive_cycle(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++; if (pc !== 32'd5) begin errors++; $display("FAIL midreset_pre_pc got %0d want 5", pc); end
        reset = 1;
        #2;
        checks++; if (pc !== 32'd0)          begin errors++; $display("FAIL midreset_pc got %0d want 0", pc); end
        checks++; if (running !== 1'b0)      begin errors++; $display("FAIL midreset_running got %b want 0", running); end
        checks++; if (done !== 1'b0)         begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        checks++; if (done_cause !== 2'b00)  begin errors++; $display("FAIL midreset_cause got %b want 00", done_cause); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL midreset_count got %0d want 0", cycle_count); end
        model_reset();
        reset = 0;
        tick();
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (m_running && n < 200) begin
            checks++;
            if (instr !== mem_model[exp_pc[4:0]]) begin errors++; $display("FAIL midreset_mem pc%0d got %h want %h", pc, instr, mem_model[exp_pc[4:0]]); end
            checks++;
            if (dut_status !== exp_status()) begin errors++; $display("FAIL midreset_step%0d got %h want %h", n, dut_status, exp_status()); end
            drive_cycle(0, 0, 0, 0, 0, 0, 0);
            n++;
        end
    endtask

    task automatic test_load_with_start();
        drive_cycle(1, 1, 5'd0, HALT, 0, 0, 0);
        checks++; if (instr !== HALT)   begin errors++; $display("FAIL loadstart_instr got %h want %h", instr, HALT); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL loadstart_running got %b want 1", running); end
        drive_cycle(0, 1, 5'd0, 16'd7, 0, 0, 0);
        checks++; if (done_cause !== 2'b01)  begin errors++; $display("FAIL loadstart_cause got %b want 01", done_cause); end
        checks++; if (cycle_count !== 32'd1) begin errors++; $display("FAIL loadstart_count got %0d want 1", cycle_count); end
        checks++; if (instr !== HALT)        begin errors++; $display("FAIL loadstart_runwrite got %h want %h", instr, HALT); end
    endtask

    task automatic test_random();
        int n;
        logic [31:0] tg;
        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < DEPTH; a++)
                drive_cycle(0, 1, 5'(a), ($urandom % 10 == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE)), 0, 0, 0);
            drive_cycle(1, $urandom % 2, 5'd0, 16'($urandom), 0, 0, 0);
            n = 0;
            while (m_running && n < 200) begin
                checks++;
                if (dut_status !== exp_status()) begin errors++; $display("FAIL random%0d_step%0d got %h want %h", r, n, dut_status, exp_status()); end
                checks++;
                if (instr !== mem_model[exp_pc[4:0]]) begin errors++; $display("FAIL random%0d_instr%0d got %h want %h", r, n, instr, mem_model[exp_pc[4:0]]); end
                case ($urandom % 6)
                    0:       tg = $urandom;
                    1:       tg = 32'($urandom_range(30, 34));
                    default: tg = 32'($urandom_range(0, 31));
                endcase
                drive_cycle($urandom % 8 == 0, $urandom % 4 == 0, 5'($urandom), 16'($urandom),
                            $urandom % 4 == 0, $urandom % 6 == 0, tg);
                n++;
            end
            checks++;
            if (m_running) begin errors++; $display("FAIL random%0d_budget got running want stopped", r); end
            checks++;
            if (dut_status !== exp_status()) begin errors++; $display("FAIL random%0d_final got %h want %h", r, dut_status, exp_status()); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load();
        test_halt();
        test_out_of_range();
        test_timeout();
        test_stall();
        test_reset_mid_run();
        test_load_with_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
